// File: rtl/q_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : q_pulse_decoder
// Description : Receive side of the resonant system emulator link. Counts
//               the rising edges of the serialized Q pulse train, closes a
//               train after an idle timeout, and presents
//               count * Q_PER_PULSE (saturated) with a valid/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module q_pulse_decoder #(
    parameter int BUS_WIDTH    = 10,
    parameter int Q_PER_PULSE  = 30,
    parameter int IDLE_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 q_serialized,
    input  logic                 ack,
    output logic [BUS_WIDTH-1:0] o_q_parallel,
    output logic [BUS_WIDTH-1:0] o_n_pulses,
    output logic                 o_valid,
    output logic                 o_sat,
    output logic                 o_busy
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_COUNT = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    // Product is wide enough for the full count times the quantum, never
    // narrower than BUS_WIDTH+7 bits.
    localparam int c_QW     = $clog2(Q_PER_PULSE + 1);
    localparam int c_PROD_W = BUS_WIDTH + ((c_QW > 7) ? c_QW : 7);

    localparam logic [BUS_WIDTH-1:0] c_CNT_MAX   = '1;
    localparam logic [c_PROD_W-1:0]  c_Q_MAX     = {{(c_PROD_W-BUS_WIDTH){1'b0}}, c_CNT_MAX};
    localparam logic [c_PROD_W-1:0]  c_QPP       = c_PROD_W'(Q_PER_PULSE);
    localparam logic [CNT_W-1:0]     c_IDLE_LAST = CNT_W'(IDLE_TIMEOUT - 1);

    logic                 r_s1;
    logic                 r_s2;
    logic                 r_s3;
    logic [1:0]           r_state;
    logic [BUS_WIDTH-1:0] r_cnt;
    logic [CNT_W-1:0]     r_idle;
    logic                 r_sat;
    logic [BUS_WIDTH-1:0] r_q_parallel;
    logic [BUS_WIDTH-1:0] r_n_pulses;
    logic                 r_valid;
    logic                 r_out_sat;

    logic                 w_rise;
    logic [c_PROD_W-1:0]  w_prod;
    logic                 w_prod_ovf;

    // One pulse is one rising edge of the synchronized train, independent of
    // the idle level of the line.
    assign w_rise     = r_s2 & ~r_s3;
    assign w_prod     = c_PROD_W'(r_cnt) * c_QPP;
    assign w_prod_ovf = (w_prod > c_Q_MAX);

    // Two-flop synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= q_serialized;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Train FSM: arm, count edges until the idle timeout, hold result until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_idle       <= '0;
            r_sat        <= 1'b0;
            r_q_parallel <= '0;
            r_n_pulses   <= '0;
            r_valid      <= 1'b0;
            r_out_sat    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt  <= '0;
                    r_idle <= '0;
                    r_sat  <= 1'b0;
                    if (start) begin
                        r_state <= c_ST_ARMED;
                    end
                end
                c_ST_ARMED: begin
                    // Abort has priority over a coincident edge.
                    if (!start) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_rise) begin
                        r_cnt   <= BUS_WIDTH'(1);
                        r_idle  <= '0;
                        r_state <= c_ST_COUNT;
                    end
                end
                c_ST_COUNT: begin
                    if (!start) begin
                        r_cnt   <= '0;
                        r_idle  <= '0;
                        r_sat   <= 1'b0;
                        r_state <= c_ST_IDLE;
                    end else if (w_rise) begin
                        // An edge on the timeout cycle keeps the train alive.
                        if (r_cnt == c_CNT_MAX) begin
                            r_sat <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + BUS_WIDTH'(1);
                        end
                        r_idle <= '0;
                    end else if (r_idle == c_IDLE_LAST) begin
                        r_state      <= c_ST_DONE;
                        r_valid      <= 1'b1;
                        r_n_pulses   <= r_cnt;
                        r_q_parallel <= w_prod_ovf ? c_CNT_MAX : w_prod[BUS_WIDTH-1:0];
                        r_out_sat    <= r_sat | w_prod_ovf;
                    end else begin
                        r_idle <= r_idle + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: result frozen; edges and start ignored until ack.
                    if (ack) begin
                        r_valid      <= 1'b0;
                        r_n_pulses   <= '0;
                        r_q_parallel <= '0;
                        r_out_sat    <= 1'b0;
                        r_cnt        <= '0;
                        r_idle       <= '0;
                        r_sat        <= 1'b0;
                        r_state      <= c_ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign o_q_parallel = r_q_parallel;
    assign o_n_pulses   = r_n_pulses;
    assign o_valid      = r_valid;
    assign o_sat        = r_out_sat;
    assign o_busy       = (r_state == c_ST_ARMED) | (r_state == c_ST_COUNT);

endmodule
`default_nettype wire

// File: tb/tb_q_pulse_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_q_pulse_decoder
// Description : Directed self-checking bench for q_pulse_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_q_pulse_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       q_serialized = 1'b0;
    logic       ack = 1'b0;
    logic [9:0] o_q_parallel;
    logic [9:0] o_n_pulses;
    logic       o_valid;
    logic       o_sat;
    logic       o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    q_pulse_decoder #(
        .BUS_WIDTH    (10),
        .Q_PER_PULSE  (30),
        .IDLE_TIMEOUT (16),
        .CNT_W        (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .q_serialized (q_serialized),
        .ack          (ack),
        .o_q_parallel (o_q_parallel),
        .o_n_pulses   (o_n_pulses),
        .o_valid      (o_valid),
        .o_sat        (o_sat),
        .o_busy       (o_busy)
    );

    always #5 clk = ~clk;

    // Stimulus helpers (inputs change on the falling edge).
    task automatic pulse(input int hi, input int lo);
        q_serialized = 1'b1;
        repeat (hi) @(negedge clk);
        q_serialized = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic pulses(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) pulse(hi, lo);
    endtask

    task automatic arm();
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_valid(input int limit, output int cycles);
        cycles = 0;
        while (!o_valid && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    // Gap between two rising edges of the input, in clock cycles.
    task automatic gap_train(input int gap);
        pulses(3, 3, 3);
        pulse(3, gap - 3);
        pulses(4, 3, 3);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d expected 0", o_valid); end
        n_checks++; if (o_n_pulses !== 10'd0) begin n_fail++; $display("FAIL reset_n: got %0d expected 0", o_n_pulses); end
        n_checks++; if (o_q_parallel !== 10'd0) begin n_fail++; $display("FAIL reset_q: got %0d expected 0", o_q_parallel); end
        n_checks++; if (o_sat !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_sat_busy: got %0d/%0d expected 0/0", o_sat, o_busy); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int k;
        int lat;
        arm();
        pulses(7, 3, 3);
        q_serialized = 1'b1;
        lat = 0;
        for (k = 1; k <= 40 && lat == 0; k++) begin
            @(negedge clk);
            if (k == 3) q_serialized = 1'b0;
            if (o_valid) lat = k;
        end
        // Edge reaches the FSM on the 3rd clock, valid follows 16 clocks later.
        n_checks++; if (lat != 19) begin n_fail++; $display("FAIL basic_latency: got %0d expected 19", lat); end
        n_checks++; if (o_n_pulses !== 10'd8) begin n_fail++; $display("FAIL basic_n: got %0d expected 8", o_n_pulses); end
        n_checks++; if (o_q_parallel !== 10'd240) begin n_fail++; $display("FAIL basic_q: got %0d expected 240", o_q_parallel); end
        n_checks++; if (o_sat !== 1'b0 || o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_sat_busy: got %0d/%0d expected 0/0", o_sat, o_busy); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++; if (o_valid !== 1'b1 || o_n_pulses !== 10'd8 || o_q_parallel !== 10'd240) begin
                n_fail++; $display("FAIL basic_hold: got v=%0d n=%0d q=%0d expected 1/8/240", o_valid, o_n_pulses, o_q_parallel);
            end
        end
        do_ack();
        n_checks++; if (o_valid !== 1'b0 || o_n_pulses !== 10'd0 || o_q_parallel !== 10'd0) begin
            n_fail++; $display("FAIL basic_ack: got v=%0d n=%0d q=%0d expected 0/0/0", o_valid, o_n_pulses, o_q_parallel);
        end
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after_ack: got %0d expected 0", o_busy); end
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b1) begin n_fail++; $display("FAIL basic_rearm: got %0d expected 1", o_busy); end
    endtask

    task automatic test_single_and_glitch();
        int c;
        arm();
        pulse(3, 3);
        wait_valid(60, c);
        n_checks++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_timeout: got %0d expected 1", o_valid); end
        n_checks++; if (o_n_pulses !== 10'd1 || o_q_parallel !== 10'd30) begin
            n_fail++; $display("FAIL single_result: got n=%0d q=%0d expected 1/30", o_n_pulses, o_q_parallel);
        end
        do_ack();
        arm();
        // Glitches narrower than a clock period that fall between sampling edges.
        for (int i = 0; i < 6; i++) begin
            #1 q_serialized = 1'b1;
            #2 q_serialized = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
        repeat (25) @(negedge clk);
        n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin
            n_fail++; $display("FAIL glitch_armed: got v=%0d busy=%0d expected 0/1", o_valid, o_busy);
        end
    endtask

    task automatic test_saturation();
        int c;
        arm();
        pulses(40, 2, 2);
        wait_valid(60, c);
        n_checks++; if (o_n_pulses !== 10'd40 || o_q_parallel !== 10'd1023 || o_sat !== 1'b1 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL sat_product: got v=%0d n=%0d q=%0d s=%0d expected 1/40/1023/1", o_valid, o_n_pulses, o_q_parallel, o_sat);
        end
        do_ack();
        arm();
        pulses(1030, 2, 2);
        wait_valid(60, c);
        n_checks++; if (o_n_pulses !== 10'd1023 || o_q_parallel !== 10'd1023 || o_sat !== 1'b1 || o_valid !== 1'b1) begin
            n_fail++; $display("FAIL sat_count: got v=%0d n=%0d q=%0d s=%0d expected 1/1023/1023/1", o_valid, o_n_pulses, o_q_parallel, o_sat);
        end
        do_ack();
    endtask

    task automatic test_abort();
        int c;
        arm();
        pulses(5, 3, 3);
        start = 1'b0;
        @(negedge clk);
        n_checks++; if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0d expected 0", o_busy); end
        pulses(5, 3, 3);
        repeat (25) @(negedge clk);
        n_checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_no_result: got v=%0d busy=%0d expected 0/0", o_valid, o_busy);
        end
        arm();
        pulses(3, 3, 3);
        wait_valid(60, c);
        n_checks++; if (o_valid !== 1'b1 || o_n_pulses !== 10'd3 || o_q_parallel !== 10'd90) begin
            n_fail++; $display("FAIL abort_next: got v=%0d n=%0d q=%0d expected 1/3/90", o_valid, o_n_pulses, o_q_parallel);
        end
        do_ack();
    endtask

    task automatic test_idle_high_and_gap();
        int c;
        start = 1'b0;
        q_serialized = 1'b1;
        repeat (6) @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            q_serialized = 1'b0;
            repeat (3) @(negedge clk);
            q_serialized = 1'b1;
            repeat (3) @(negedge clk);
        end
        wait_valid(60, c);
        n_checks++; if (o_valid !== 1'b1 || o_n_pulses !== 10'd4 || o_q_parallel !== 10'd120) begin
            n_fail++; $display("FAIL idle_high: got v=%0d n=%0d q=%0d expected 1/4/120", o_valid, o_n_pulses, o_q_parallel);
        end
        do_ack();
        q_serialized = 1'b0;
        arm();
        gap_train(15);
        wait_valid(60, c);
        n_checks++; if (o_valid !== 1'b1 || o_n_pulses !== 10'd8) begin
            n_fail++; $display("FAIL gap15: got v=%0d n=%0d expected 1/8", o_valid, o_n_pulses);
        end
        do_ack();
        arm();
        // Edge lands exactly on the timeout cycle and must extend the train.
        gap_train(16);
        wait_valid(60, c);
        n_checks++; if (o_valid !== 1'b1 || o_n_pulses !== 10'd8) begin
            n_fail++; $display("FAIL gap16: got v=%0d n=%0d expected 1/8", o_valid, o_n_pulses);
        end
        do_ack();
    endtask

    task automatic test_reset_mid();
        int c;
        arm();
        pulses(6, 3, 3);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (o_busy !== 1'b0 || o_valid !== 1'b0 || o_n_pulses !== 10'd0) begin
            n_fail++; $display("FAIL rst_count: got busy=%0d v=%0d n=%0d expected 0/0/0", o_busy, o_valid, o_n_pulses);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulses(2, 3, 3);
        wait_valid(60, c);
        n_checks++; if (o_valid !== 1'b1 || o_n_pulses !== 10'd2 || o_q_parallel !== 10'd60) begin
            n_fail++; $display("FAIL rst_recount: got v=%0d n=%0d q=%0d expected 1/2/60", o_valid, o_n_pulses, o_q_parallel);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (o_valid !== 1'b0 || o_n_pulses !== 10'd0 || o_q_parallel !== 10'd0 || o_sat !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid: got v=%0d n=%0d q=%0d expected 0/0/0", o_valid, o_n_pulses, o_q_parallel);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulses(3, 3, 3);
        wait_valid(60, c);
        n_checks++; if (o_valid !== 1'b1 || o_n_pulses !== 10'd3) begin
            n_fail++; $display("FAIL rst_after_valid: got v=%0d n=%0d expected 1/3", o_valid, o_n_pulses);
        end
        do_ack();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_single_and_glitch();
        test_saturation();
        test_abort();
        test_idle_high_and_gap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
